// File: rtl/loop_uhat_sparse_mac_pipe.sv
// Pipelined signed/unsigned multiplier with optional accumulate, clock-enable stall
// and saturating/wrapping output formatting.
module loop_uhat_sparse_mac_pipe #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 71,
    parameter int DOUT_WIDTH = 71,
    parameter int NUM_STAGE  = 5,
    parameter int IS_SIGNED  = 1,
    parameter int ACC_EN     = 0,
    parameter int ACC_GUARD  = 8,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic                  acc_clr,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_vld,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int P    = DIN0_WIDTH + DIN1_WIDTH;
    localparam int A    = P + ACC_GUARD;
    // One spare bit so the range-check slices are never empty.
    localparam int W    = ((A > DOUT_WIDTH) ? A : DOUT_WIDTH) + 1;
    localparam int NDLY = NUM_STAGE - 2;
    localparam bit OVF_POSSIBLE = (ACC_EN != 0) ? (DOUT_WIDTH < A) : (DOUT_WIDTH < P);

    logic [DIN0_WIDTH-1:0]      d0_q;
    logic [DIN1_WIDTH-1:0]      d1_q;
    logic [NUM_STAGE-1:0]       vld_pipe;
    logic [NUM_STAGE-2:0]       clr_pipe;
    logic [NDLY-1:0][P-1:0]     prod_pipe;
    logic [A-1:0]               acc;

    logic [P-1:0]               op0_x, op1_x, product, prod_last;
    logic [A-1:0]               prod_a, acc_sum;
    logic [W-1:0]               val_w;
    logic [W-DOUT_WIDTH:0]      top_s;
    logic                       fits, ovf_c;
    logic [DOUT_WIDTH-1:0]      sat_val, dout_c;

    // Operands widened to P bits; the low P bits of the P x P product are exact.
    generate
        if (IS_SIGNED != 0) begin : g_sext
            assign op0_x  = P'($signed(d0_q));
            assign op1_x  = P'($signed(d1_q));
            assign prod_a = A'($signed(prod_last));
            assign val_w  = W'($signed(acc_sum));
        end else begin : g_zext
            assign op0_x  = P'(d0_q);
            assign op1_x  = P'(d1_q);
            assign prod_a = A'(prod_last);
            assign val_w  = W'(acc_sum);
        end
    endgenerate

    assign product   = op0_x * op1_x;
    assign prod_last = prod_pipe[NDLY-1];
    assign acc_sum   = ((ACC_EN == 0) || clr_pipe[NUM_STAGE-2]) ? prod_a : acc + prod_a;
    assign top_s     = val_w[W-1:DOUT_WIDTH-1];

    always_comb begin
        fits    = 1'b1;
        sat_val = '1;
        if (IS_SIGNED != 0) begin
            fits    = (top_s == '0) || (top_s == '1);
            sat_val = val_w[W-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else begin
            fits = (val_w[W-1:DOUT_WIDTH] == '0);
        end
        ovf_c  = OVF_POSSIBLE && !fits;
        dout_c = (ovf_c && (SATURATE != 0)) ? sat_val : val_w[DOUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_q      <= '0;
            d1_q      <= '0;
            vld_pipe  <= '0;
            clr_pipe  <= '0;
            prod_pipe <= '0;
            acc       <= '0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            d0_q         <= din0;
            d1_q         <= din1;
            vld_pipe     <= {vld_pipe[NUM_STAGE-2:0], in_vld};
            clr_pipe     <= {clr_pipe[NUM_STAGE-3:0], in_vld & acc_clr};
            prod_pipe[0] <= product;
            for (int k = 1; k < NDLY; k++) prod_pipe[k] <= prod_pipe[k-1];
            // Bubbles leave acc, dout and ovf untouched.
            if (vld_pipe[NUM_STAGE-2]) begin
                acc  <= acc_sum;
                dout <= dout_c;
                ovf  <= ovf_c;
            end
        end
    end

    assign out_vld = vld_pipe[NUM_STAGE-1];

endmodule

// File: tb/tb_loop_uhat_sparse_mac_pipe.sv
// Bench: default, wrapping, accumulating and 8-bit unsigned instances on shared stimulus,
// checked against plain-arithmetic reference results.
module tb_loop_uhat_sparse_mac_pipe;
    localparam int N = 5;

    logic clk = 1'b0;
    logic reset, ce, in_vld, acc_clr;
    logic [12:0] din0;
    logic [70:0] din1;
    logic [7:0]  u0, u1;
    logic        vld_d, ovf_d, vld_w, ovf_w, vld_a, ovf_a, vld_u, ovf_u;
    logic [70:0] dout_d, dout_w, dout_a;
    logic [7:0]  dout_u;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    loop_uhat_sparse_mac_pipe dut (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_vld(vld_d), .dout(dout_d), .ovf(ovf_d));
    loop_uhat_sparse_mac_pipe #(.SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_vld(vld_w), .dout(dout_w), .ovf(ovf_w));
    loop_uhat_sparse_mac_pipe #(.ACC_EN(1)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .acc_clr(acc_clr),
        .din0(din0), .din1(din1), .out_vld(vld_a), .dout(dout_a), .ovf(ovf_a));
    loop_uhat_sparse_mac_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .IS_SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .acc_clr(acc_clr),
        .din0(u0), .din1(u1), .out_vld(vld_u), .dout(dout_u), .ovf(ovf_u));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [127:0] smul(input logic [12:0] a, input logic [70:0] b);
        logic signed [127:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // {ovf, dout} for a 71-bit signed result range.
    function automatic logic [71:0] fmt71(input logic signed [127:0] v, input bit sat);
        logic signed [127:0] mx, mn;
        logic [70:0] d;
        logic o;
        mx = (128'sd1 <<< 70) - 128'sd1;
        mn = -(128'sd1 <<< 70);
        o  = (v > mx) || (v < mn);
        d  = v[70:0];
        if (o && sat) d = (v > mx) ? mx[70:0] : mn[70:0];
        return {o, d};
    endfunction

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; in_vld = 1'b0; acc_clr = 1'b0;
        din0 = '0; din1 = '0; u0 = '0; u1 = '0;
        step(); step();
        checks++;
        if ({vld_d, ovf_d, dout_d, vld_a, ovf_a, dout_a} !== '0) begin
            failures++; $display("FAIL reset_state: got vld=%b ovf=%b dout=%0h acc_dout=%0h, expected all 0", vld_d, ovf_d, dout_d, dout_a);
        end
        checks++;
        if ({vld_w, ovf_w, dout_w, vld_u, ovf_u, dout_u} !== '0) begin
            failures++; $display("FAIL reset_state_aux: got wrap dout=%0h u8 dout=%0h, expected 0", dout_w, dout_u);
        end
        reset = 1'b0; ce = 1'b1;
        step();
    endtask

    task automatic test_plain();
        din0 = 13'(-3); din1 = 71'd5; in_vld = 1'b1; acc_clr = 1'b0;
        for (int s = 0; s < 6; s++) begin
            step();
            in_vld = 1'b0;
            checks++;
            if (vld_d !== (s == N-1)) begin
                failures++; $display("FAIL plain_latency: step %0d got out_vld=%b expected %b", s, vld_d, (s == N-1));
            end
            if (s >= N-1) begin
                checks++;
                if (dout_d !== 71'(-15) || ovf_d !== 1'b0) begin
                    failures++; $display("FAIL plain_value: step %0d got dout=%0h ovf=%b expected %0h ovf=0", s, dout_d, ovf_d, 71'(-15));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] a[10];
        logic [70:0] b[10];
        logic [71:0] r;
        for (int i = 0; i < 10; i++) begin
            a[i] = 13'($urandom());
            b[i] = (i % 2 == 0) ? 71'({$urandom(), $urandom(), $urandom()}) : 71'($signed(int'($urandom_range(0, 2000)) - 1000));
        end
        for (int i = 0; i < 10 + N; i++) begin
            in_vld = (i < 10);
            if (i < 10) begin din0 = a[i]; din1 = b[i]; end
            step();
            checks++;
            if (vld_d !== (i >= N-1 && i < N-1+10)) begin
                failures++; $display("FAIL b2b_valid: cycle %0d got out_vld=%b", i, vld_d);
            end
            if (i >= N-1 && i < N-1+10) begin
                r = fmt71(smul(a[i-N+1], b[i-N+1]), 1'b1);
                checks++;
                if ({ovf_d, dout_d} !== r) begin
                    failures++; $display("FAIL b2b_value: result %0d got ovf=%b dout=%0h expected ovf=%b dout=%0h", i-N+1, ovf_d, dout_d, r[71], r[70:0]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [71:0] r;
        din0 = 13'h1000; din1 = {1'b1, 70'd0}; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        repeat (N-1) step();
        checks++;
        if (dout_d !== {1'b0, {70{1'b1}}} || ovf_d !== 1'b1) begin
            failures++; $display("FAIL sat_pos: got dout=%0h ovf=%b expected %0h ovf=1", dout_d, ovf_d, {1'b0, {70{1'b1}}});
        end
        checks++;
        if (dout_w !== 71'd0 || ovf_w !== 1'b1) begin
            failures++; $display("FAIL wrap_pos: got dout=%0h ovf=%b expected 0 ovf=1", dout_w, ovf_w);
        end
        din0 = 13'h1000; din1 = {1'b0, {70{1'b1}}}; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        repeat (N-1) step();
        checks++;
        if (dout_d !== {1'b1, 70'd0} || ovf_d !== 1'b1) begin
            failures++; $display("FAIL sat_neg: got dout=%0h ovf=%b expected %0h ovf=1", dout_d, ovf_d, {1'b1, 70'd0});
        end
        r = fmt71(smul(13'h1000, {1'b0, {70{1'b1}}}), 1'b0);
        checks++;
        if ({ovf_w, dout_w} !== r || dout_w !== 71'd4096) begin
            failures++; $display("FAIL wrap_neg: got dout=%0h ovf=%b expected 1000 ovf=1", dout_w, ovf_w);
        end
    endtask

    task automatic test_accumulate();
        logic [12:0] a[3];
        logic [70:0] b[3];
        bit          c[3];
        logic [70:0] e[3];
        a = '{13'd2, 13'd4, 13'(-1)};
        b = '{71'd3, 71'd5, 71'd7};
        c = '{1'b1, 1'b0, 1'b0};
        e = '{71'd6, 71'd26, 71'd19};
        for (int s = 0; s < 8; s++) begin
            in_vld = (s < 3);
            if (s < 3) begin din0 = a[s]; din1 = b[s]; acc_clr = c[s]; end
            else acc_clr = 1'b0;
            step();
            checks++;
            if (vld_a !== (s >= N-1 && s < N+2)) begin
                failures++; $display("FAIL acc_valid: step %0d got out_vld=%b", s, vld_a);
            end
            if (s >= N-1) begin
                checks++;
                if (dout_a !== e[(s < N+2) ? s-N+1 : 2] || ovf_a !== 1'b0) begin
                    failures++; $display("FAIL acc_value: step %0d got dout=%0h ovf=%b expected %0h", s, dout_a, ovf_a, e[(s < N+2) ? s-N+1 : 2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [70:0] held;
        logic [71:0] r;
        din0 = 13'(-7); din1 = 71'd123456789; in_vld = 1'b1;
        r = fmt71(smul(din0, din1), 1'b1);
        held = dout_d;
        for (int s = 0; s < 14; s++) begin
            ce = !(s >= 2 && s <= 4);
            // ce=0 with in_vld=1 must be dropped
            in_vld = (s == 0) || (s >= 2 && s <= 4);
            if (s > 0) begin din0 = 13'($urandom()); din1 = 71'($urandom()); end
            step();
            checks++;
            if (vld_d !== (s == 7)) begin
                failures++; $display("FAIL stall_valid: cycle %0d got out_vld=%b expected %b", s+1, vld_d, (s == 7));
            end
            if (s >= 2 && s <= 4) begin
                checks++;
                if (dout_d !== held) begin
                    failures++; $display("FAIL stall_hold: cycle %0d got dout=%0h expected %0h", s+1, dout_d, held);
                end
            end
            if (s == 7) begin
                checks++;
                if ({ovf_d, dout_d} !== r) begin
                    failures++; $display("FAIL stall_value: got dout=%0h expected %0h", dout_d, r[70:0]);
                end
            end
        end
        ce = 1'b1; in_vld = 1'b0;
    endtask

    task automatic test_unsigned8();
        u0 = 8'd255; u1 = 8'd255; in_vld = 1'b1;
        step();
        u0 = 8'd15; u1 = 8'd17;
        step(); in_vld = 1'b0;
        repeat (N-2) step();
        checks++;
        if (vld_u !== 1'b1 || dout_u !== 8'hFF || ovf_u !== 1'b1) begin
            failures++; $display("FAIL u8_sat: got vld=%b dout=%0h ovf=%b expected vld=1 ff ovf=1", vld_u, dout_u, ovf_u);
        end
        step();
        checks++;
        if (vld_u !== 1'b1 || dout_u !== 8'd255 || ovf_u !== 1'b0) begin
            failures++; $display("FAIL u8_fit: got vld=%b dout=%0h ovf=%b expected vld=1 ff ovf=0", vld_u, dout_u, ovf_u);
        end
        step();
    endtask

    task automatic test_random();
        localparam int M = 300;
        bit          hv[M+1];
        bit          hc[M+1];
        logic [12:0] ha[M+1];
        logic [70:0] hb[M+1];
        logic [7:0]  hu0[M+1], hu1[M+1];
        logic signed [91:0]  macc;
        logic signed [127:0] p, t;
        logic [71:0] r;
        int  e, src, up, mode;
        bit  first, c, v, ev, last_ev;
        e = 0; first = 1'b1; last_ev = 1'b0; macc = '0;
        for (int i = 0; i < M; i++) begin
            c = (i >= M-6) || ($urandom_range(0, 9) != 0);
            v = (i < M-6) && ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                din0 = 13'($urandom()); din1 = 71'({$urandom(), $urandom(), $urandom()});
            end else if (mode == 1) begin
                din0 = 13'($signed(int'($urandom_range(0, 200)) - 100));
                din1 = 71'($signed(int'($urandom_range(0, 20000)) - 10000));
            end else begin
                din0 = $urandom_range(0, 1) ? 13'h1000 : 13'h0FFF;
                din1 = $urandom_range(0, 1) ? {1'b1, 70'd0} : {1'b0, {70{1'b1}}};
            end
            u0 = 8'($urandom()); u1 = 8'($urandom());
            acc_clr = first ? 1'b1 : ($urandom_range(0, 3) == 0);
            ce = c; in_vld = v;
            step();
            if (c) begin
                hv[e] = v; hc[e] = acc_clr; ha[e] = din0; hb[e] = din1; hu0[e] = u0; hu1[e] = u1;
                if (v) first = 1'b0;
                src = e - (N-1);
                ev = (src >= 0) && hv[src];
                e++;
            end else ev = last_ev;
            last_ev = ev;
            checks++;
            if ({vld_d, vld_w, vld_a, vld_u} !== {4{ev}}) begin
                failures++; $display("FAIL rand_valid: cycle %0d got %b%b%b%b expected %b", i, vld_d, vld_w, vld_a, vld_u, ev);
            end
            if (c && ev) begin
                p = smul(ha[src], hb[src]);
                r = fmt71(p, 1'b1);
                checks++;
                if ({ovf_d, dout_d} !== r) begin
                    failures++; $display("FAIL rand_sat: cycle %0d got ovf=%b dout=%0h expected ovf=%b dout=%0h", i, ovf_d, dout_d, r[71], r[70:0]);
                end
                r = fmt71(p, 1'b0);
                checks++;
                if ({ovf_w, dout_w} !== r) begin
                    failures++; $display("FAIL rand_wrap: cycle %0d got ovf=%b dout=%0h expected ovf=%b dout=%0h", i, ovf_w, dout_w, r[71], r[70:0]);
                end
                macc = hc[src] ? 92'(p) : macc + 92'(p);
                t = macc;
                r = fmt71(t, 1'b1);
                checks++;
                if ({ovf_a, dout_a} !== r) begin
                    failures++; $display("FAIL rand_acc: cycle %0d got ovf=%b dout=%0h expected ovf=%b dout=%0h", i, ovf_a, dout_a, r[71], r[70:0]);
                end
                up = int'(hu0[src]) * int'(hu1[src]);
                checks++;
                if (ovf_u !== (up > 255) || dout_u !== ((up > 255) ? 8'hFF : 8'(up))) begin
                    failures++; $display("FAIL rand_u8: cycle %0d got ovf=%b dout=%0h for %0d", i, ovf_u, dout_u, up);
                end
            end
        end
        ce = 1'b1; in_vld = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic test_reset_midflight();
        din0 = 13'd9; din1 = 71'd11; in_vld = 1'b1; acc_clr = 1'b1;
        step();
        din0 = 13'd5; din1 = 71'd6;
        step();
        in_vld = 1'b0; acc_clr = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({vld_d, dout_d, vld_a, dout_a, vld_w, dout_w} !== '0) begin
            failures++; $display("FAIL reset_async: got vld=%b dout=%0h acc dout=%0h expected 0", vld_d, dout_d, dout_a);
        end
        step(); step();
        reset = 1'b0;
        for (int s = 0; s < 10; s++) begin
            step();
            checks++;
            if ({vld_d, vld_w, vld_a, vld_u} !== 4'b0) begin
                failures++; $display("FAIL reset_flush: cycle %0d got valids %b%b%b%b expected 0000", s, vld_d, vld_w, vld_a, vld_u);
            end
        end
        // acc starts from zero after reset even without acc_clr
        din0 = 13'd3; din1 = 71'd4; in_vld = 1'b1; acc_clr = 1'b0;
        step(); in_vld = 1'b0;
        repeat (N-1) step();
        checks++;
        if (vld_a !== 1'b1 || dout_a !== 71'd12) begin
            failures++; $display("FAIL reset_acc_zero: got vld=%b dout=%0h expected vld=1 dout=c", vld_a, dout_a);
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_back_to_back();
        test_saturation();
        test_accumulate();
        test_stall();
        test_unsigned8();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
